apb_fsm_controller: RTL and testbench

- APB-side sequencing FSM of the AHB2APB bridge.
- Takes qualified AHB transfers from the AHB slave interface (valid, Haddr, Hwrite, Hwdata).
- Drives the APB master signals through SETUP/ENABLE phases and stalls the AHB master via Hreadyout until each APB transfer completes.
- Read data is not registered here: Hrdata = Prdata is passed through by the slave interface.

---
 rtl/apb_bridge_pkg.sv | 38 +++
 rtl/apb_fsm_controller.sv | 121 ++++++++++++
 tb/tb_apb_fsm_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and address map for the AHB2APB bridge.
// Slave regions are 64 MB windows starting at 0x8000_0000.
package apb_bridge_pkg;

   localparam int SLV_NUM = 3;

   localparam logic [31:0] REGION_SZ = 32'h0400_0000;

   localparam logic [SLV_NUM-1:0][31:0] SLV_BASE = {
      32'h8800_0000,
      32'h8400_0000,
      32'h8000_0000
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_READ,
      ST_WRITE,
      ST_RENABLE,
      ST_WENABLE
   } apb_state_e;

   // Unsigned wrap makes addr below base land far above REGION_SZ.
   function automatic logic [SLV_NUM-1:0] decode_sel(
      input logic [31:0] addr
   );
      logic [SLV_NUM-1:0] sel;
      sel = '0;
      for (int i = 0; i < SLV_NUM; i++) begin
         if ((addr - SLV_BASE[i]) < REGION_SZ) begin
            sel[i] = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// APB-side sequencing FSM of the AHB2APB bridge.
// Runs SETUP/ACCESS phases and stalls AHB via Hreadyout.
module apb_fsm_controller
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NSLV   = SLV_NUM
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              valid,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic              Hwrite,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic              Pready,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Pwrite,
   output logic [NSLV-1:0]   Pselx,
   output logic              Penable,
   output logic              Hreadyout
);

   apb_state_e      state;
   logic [NSLV-1:0] sel;
   logic [NSLV-1:0] new_sel;
   logic            accept;
   logic            in_access;

   assign new_sel   = NSLV'(decode_sel(Haddr[31:0]));
   assign in_access = (state == ST_RENABLE) ||
                      (state == ST_WENABLE);
   assign accept    = Hreadyout & valid;

   always_comb begin
      unique case (state)
         ST_IDLE:                Hreadyout = 1'b1;
         ST_RENABLE, ST_WENABLE: Hreadyout = Pready;
         default:                Hreadyout = 1'b0;
      endcase
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state <= ST_IDLE;
         sel   <= '0;
      end else begin
         if (accept) begin
            sel <= new_sel;
         end
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= Hwrite ? ST_WWAIT : ST_READ;
               end
            end
            ST_WWAIT: state <= ST_WRITE;
            ST_READ:  state <= ST_RENABLE;
            ST_WRITE: state <= ST_WENABLE;
            ST_RENABLE, ST_WENABLE: begin
               if (Pready) begin
                  if (!accept) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= Hwrite ? ST_WWAIT : ST_READ;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A read accepted at completion enters SETUP directly.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         Paddr   <= '0;
         Pwdata  <= '0;
         Pwrite  <= 1'b0;
         Pselx   <= '0;
         Penable <= 1'b0;
      end else begin
         if (accept) begin
            Paddr  <= Haddr;
            Pwrite <= Hwrite;
         end
         unique case (state)
            ST_IDLE: begin
               if (accept && !Hwrite) begin
                  Pselx <= new_sel;
               end
            end
            ST_WWAIT: begin
               Pwdata <= Hwdata;
               Pselx  <= sel;
            end
            ST_READ, ST_WRITE: begin
               Penable <= 1'b1;
            end
            ST_RENABLE, ST_WENABLE: begin
               if (Pready) begin
                  Penable <= 1'b0;
                  if (accept && !Hwrite) begin
                     Pselx <= new_sel;
                  end else begin
                     Pselx <= '0;
                  end
               end
            end
            default: begin
               Penable <= 1'b0;
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = in_access;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Randomized bench for apb_fsm_controller.
// Reference model tracks transfers by phase count since acceptance.
module tb_apb_fsm_controller;

   logic        Hclk;
   logic        Hresetn;
   logic        valid;
   logic [31:0] Haddr;
   logic        Hwrite;
   logic [31:0] Hwdata;
   logic        Pready;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Pwrite;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Hreadyout;

   int n_checks = 0;
   int n_fail   = 0;

   logic        busy = 1'b0;
   int          cyc  = 0;
   int          base = 0;
   logic [31:0] m_addr = '0;
   logic        m_wr = 1'b0;
   logic [31:0] m_wdata = '0;
   logic [2:0]  m_sel = '0;

   apb_fsm_controller dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .valid     (valid),
      .Haddr     (Haddr),
      .Hwrite    (Hwrite),
      .Hwdata    (Hwdata),
      .Pready    (Pready),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Pwrite    (Pwrite),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Hreadyout (Hreadyout)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_sel(input logic [31:0] a);
      logic [31:0] idx;
      if (a >= 32'h8000_0000 && a < 32'h8C00_0000) begin
         idx = (a - 32'h8000_0000) / 32'h0400_0000;
         return 3'b001 << idx;
      end
      return 3'b000;
   endfunction

   task automatic do_cycle(input logic        v,
                           input logic [31:0] a,
                           input logic        w,
                           input logic [31:0] wd,
                           input logic        pr);
      logic done;
      logic exp_rdy;
      @(negedge Hclk);
      if (busy) cyc++;
      Pready = pr;
      if (busy && m_wr && cyc == 1) Hwdata = m_wdata;
      else Hwdata = $urandom;
      valid  = v;
      Haddr  = a;
      Hwrite = w;
      done    = busy && (cyc > base) && pr;
      exp_rdy = !busy || done;
      #1;
      chk("hreadyout", {31'b0, Hreadyout}, {31'b0, exp_rdy});
      if (!busy || (m_wr && cyc == 1)) begin
         chk("pselx_idle", {29'b0, Pselx}, 32'h0);
         chk("penable_idle", {31'b0, Penable}, 32'h0);
      end else begin
         chk("pselx", {29'b0, Pselx}, {29'b0, m_sel});
         chk("penable", {31'b0, Penable},
             (cyc > base) ? 32'h1 : 32'h0);
         chk("paddr", Paddr, m_addr);
         chk("pwrite", {31'b0, Pwrite}, {31'b0, m_wr});
         if (m_wr) chk("pwdata", Pwdata, m_wdata);
      end
      if (done) busy = 1'b0;
      if (v && exp_rdy) begin
         busy    = 1'b1;
         cyc     = 0;
         m_addr  = a;
         m_wr    = w;
         m_wdata = wd;
         m_sel   = exp_sel(a);
         base    = w ? 2 : 1;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         do_cycle(1'b0, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_hready"}, {31'b0, Hreadyout}, 32'h1);
      chk({tag, "_pselx"}, {29'b0, Pselx}, 32'h0);
      chk({tag, "_penable"}, {31'b0, Penable}, 32'h0);
      chk({tag, "_paddr"}, Paddr, 32'h0);
      chk({tag, "_pwdata"}, Pwdata, 32'h0);
      chk({tag, "_pwrite"}, {31'b0, Pwrite}, 32'h0);
   endtask

   initial begin
      Hresetn = 1'b0;
      valid   = 1'b0;
      Haddr   = '0;
      Hwrite  = 1'b0;
      Hwdata  = '0;
      Pready  = 1'b1;
      #1;
      check_reset_vals("reset");
      @(negedge Hclk);
      @(negedge Hclk);
      Hresetn = 1'b1;

      // Write 0x8000_0001 / 0xDEADBEEF
      do_cycle(1'b1, 32'h8000_0001, 1'b1, 32'hDEAD_BEEF, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("tp_w_pwdata", Pwdata, 32'hDEAD_BEEF);
      chk("tp_w_pselx", {29'b0, Pselx}, 32'h1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("tp_w_penable", {31'b0, Penable}, 32'h1);
      idle_cycles(2);

      // Read 0x8400_0010
      do_cycle(1'b1, 32'h8400_0010, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("tp_r_pselx", {29'b0, Pselx}, 32'h2);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle_cycles(1);

      // Read 0x8800_0004 with three stall cycles
      do_cycle(1'b1, 32'h8800_0004, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         chk("tp_stall_pselx", {29'b0, Pselx}, 32'h4);
      end
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle_cycles(1);

      // Write then read accepted back-to-back
      do_cycle(1'b1, 32'h8000_0008, 1'b1, 32'h1234_5678, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b1, 32'h8400_0000, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("tp_b2b_pselx", {29'b0, Pselx}, 32'h2);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle_cycles(1);

      // Reset asserted while a write is held in ACCESS
      do_cycle(1'b1, 32'h8000_0020, 1'b1, 32'hA5A5_5A5A, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      valid = 1'b0;
      #2 Hresetn = 1'b0;
      #1;
      check_reset_vals("midrst");
      busy = 1'b0;
      @(negedge Hclk);
      Hresetn = 1'b1;
      do_cycle(1'b1, 32'h8400_0100, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // Out-of-range address with valid low
      idle_cycles(5);

      for (int n = 0; n < 3000; n++) begin
         logic        v;
         logic        w;
         logic        pr;
         logic [31:0] a;
         int          idx;
         v   = 1'($urandom_range(0, 1));
         w   = 1'($urandom_range(0, 1));
         pr  = ($urandom_range(0, 3) != 0);
         idx = $urandom_range(0, 2);
         if (v) a = 32'h8000_0000 + idx * 32'h0400_0000 +
                    ($urandom & 32'h03FF_FFFF);
         else a = $urandom;
         do_cycle(v, a, w, $urandom, pr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
